shift_rx: RTL and testbench

Serial-in, parallel-out frame receiver; the receive end of the team's serial shift-register transmitter link. Samples a single serial line on a bit-rate enable, detects start bit, shifts in WIDTH data bits, and checks the stop bit. Presents the assembled word on a parallel bus with a valid/ready handshake. Flags framing errors and overruns.

---
 rtl/serial_pkg.sv | 14 +
 rtl/shift_rx_shreg.sv | 41 ++++
 rtl/shift_rx.sv | 162 ++++++++++++++++
 tb/tb_shift_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Constants shared by the serial shift-register link: the FSM state encodings
// and the line levels used by both the transmitter and the receiver.
package serial_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/shift_rx_shreg.sv
// rx_shreg: WIDTH-bit receive shift register with synchronous clear and
// shift-enable; MSB_FIRST selects which end the serial bit enters from.
module rx_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                q_d = {q_q[WIDTH-2:0], sin_i};
            end else begin
                q_d = {sin_i, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/shift_rx.sv
// shift_rx: serial-in, parallel-out frame receiver with valid/ready output.
// Defining SHIFT_RX_PARITY_EN adds an even-parity bit and the parity_err port.
//
// state  | meaning
// IDLE   | waiting for a start bit (line low on bit_en)
// DATA   | shifting in WIDTH data bits
// PARITY | sampling the even-parity bit (SHIFT_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then load / overrun / frame error
module shift_rx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
`ifdef SHIFT_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             sh_clr;
    logic             sh_shift;
    logic [WIDTH-1:0] shreg;
    logic             par_bad;
`ifdef SHIFT_RX_PARITY_EN
    logic             pbad_q, pbad_d;
    logic             perr_q, perr_d;
`endif

    rx_shreg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sh_clr),
        .shift_i(sh_shift),
        .sin_i  (sin),
        .q_o    (shreg)
    );

`ifdef SHIFT_RX_PARITY_EN
    assign par_bad = pbad_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        sh_clr   = 1'b0;
        sh_shift = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
        pbad_d   = pbad_q;
        perr_d   = 1'b0;
`endif
        if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (sin == START_BIT) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        sh_clr  = 1'b1;
                    end
                end
                ST_DATA: begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SHIFT_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
`ifdef SHIFT_RX_PARITY_EN
                ST_PARITY: begin
                    pbad_d  = (^shreg) ^ sin;
                    state_d = ST_STOP;
                end
`endif
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // A frame error outranks everything; a good word may still
                    // load on the same edge the consumer takes the old one.
                    if (sin != STOP_BIT) begin
                        ferr_d = 1'b1;
                    end else if (par_bad) begin
`ifdef SHIFT_RX_PARITY_EN
                        perr_d = 1'b1;
`endif
                    end else if (valid_q && !dout_ready) begin
                        ovr_d = 1'b1;
                    end else begin
                        dout_d  = shreg;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef SHIFT_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
`ifdef SHIFT_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_shift_rx.sv
// Self-checking bench for shift_rx: an LSB-first and an MSB-first instance
// share stimulus and are compared every cycle against a frame-level model.
module tb_shift_rx;

    localparam int W = 8;
`ifdef SHIFT_RX_PARITY_EN
    localparam int FLEN = W + 3;
`else
    localparam int FLEN = W + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_en = 1'b0;
    logic sin = 1'b1;
    logic dout_ready = 1'b0;
    logic [W-1:0] dout_l, dout_m;
    logic vl, vm, fel, fem, ovl, ovm;
`ifdef SHIFT_RX_PARITY_EN
    logic perl, perm;
`endif

    always #5 clk = ~clk;

    shift_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
        .dout(dout_l), .dout_valid(vl), .dout_ready(dout_ready),
        .frame_err(fel),
`ifdef SHIFT_RX_PARITY_EN
        .parity_err(perl),
`endif
        .overrun(ovl)
    );

    shift_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin),
        .dout(dout_m), .dout_valid(vm), .dout_ready(dout_ready),
        .frame_err(fem),
`ifdef SHIFT_RX_PARITY_EN
        .parity_err(perm),
`endif
        .overrun(ovm)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect sampled bits from the start bit, judge the
    // frame when all FLEN bits are in.
    logic         mbits[$];
    logic [W-1:0] m_dl, m_dm;
    logic         m_v, m_fe, m_ov, m_pe;

    always @(posedge clk or negedge rst_n) begin
        logic         v_pre;
        logic [W-1:0] d;
        logic         stop_b, pbad;
        if (!rst_n) begin
            mbits.delete();
            m_dl = '0; m_dm = '0;
            m_v = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
        end else begin
            v_pre = m_v;
            m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
            if (m_v && dout_ready) m_v = 1'b0;
            if (bit_en) begin
                if (mbits.size() != 0 || sin == 1'b0) mbits.push_back(sin);
                if (mbits.size() == FLEN) begin
                    d = '0;
                    for (int i = 0; i < W; i++) d[i] = mbits[1 + i];
                    stop_b = mbits[FLEN - 1];
                    pbad = (FLEN == W + 3) ? ((^d) ^ mbits[W + 1]) : 1'b0;
                    if (!stop_b) m_fe = 1'b1;
                    else if (pbad) m_pe = 1'b1;
                    else if (v_pre && !dout_ready) m_ov = 1'b1;
                    else begin
                        m_dl = d;
                        for (int i = 0; i < W; i++) m_dm[W - 1 - i] = d[i];
                        m_v = 1'b1;
                    end
                    mbits.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("dout_lsb", dout_l, m_dl);
        chk("dout_msb", dout_m, m_dm);
        chk("valid_lsb", vl, m_v);
        chk("valid_msb", vm, m_v);
        chk("frame_err", {fem, fel}, {m_fe, m_fe});
        chk("overrun", {ovm, ovl}, {m_ov, m_ov});
`ifdef SHIFT_RX_PARITY_EN
        chk("parity_err", {perm, perl}, {m_pe, m_pe});
`endif
    end

    int ready_mode = 1;

    task automatic cyc(input logic en, input logic s);
        bit_en = en;
        sin = s;
        case (ready_mode)
            0: dout_ready = 1'b0;
            1: dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int sp);
        for (int i = 1; i < sp; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
        cyc(1'b1, b);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input int sp,
                              input logic pflip);
        send_bit(1'b0, sp);
        for (int i = 0; i < W; i++) send_bit(d[i], sp);
`ifdef SHIFT_RX_PARITY_EN
        send_bit((^d) ^ pflip, sp);
`else
        if (pflip) send_bit(1'b1, sp);
`endif
        send_bit(stop_b, sp);
    endtask

    initial begin
        logic [W-1:0] rd;
        int sp;
        ready_mode = 1;
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b1);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        chk("rst_dout", dout_l, 0);
        chk("rst_valid", vl, 0);
        chk("rst_pulses", {fel, ovl}, 0);

        send_frame(8'hA5, 1'b1, 1, 1'b0);
        chk("a5_lsb", dout_l, 8'hA5);
        chk("a5_msb", dout_m, 8'hA5);
        chk("a5_valid", vl, 1);
        chk("a5_no_err", {fel, ovl}, 0);
        cyc(1'b1, 1'b1);
        chk("a5_valid_drop", vl, 0);

        send_frame(8'h01, 1'b1, 1, 1'b0);
        chk("x01_lsb", dout_l, 8'h01);
        chk("x01_msb", dout_m, 8'h80);
        cyc(1'b1, 1'b1);

        ready_mode = 0;
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        chk("b2b_first", dout_l, 8'h3C);
        send_frame(8'hC3, 1'b1, 1, 1'b0);
        chk("b2b_overrun", ovl, 1);
        chk("b2b_held", dout_l, 8'h3C);
        cyc(1'b1, 1'b1);
        chk("b2b_ovr_clear", ovl, 0);
        chk("b2b_still_valid", vl, 1);
        ready_mode = 1;
        cyc(1'b1, 1'b1);
        chk("b2b_drop", vl, 0);

        send_frame(8'h55, 1'b0, 1, 1'b0);
        chk("ferr_pulse", fel, 1);
        chk("ferr_no_valid", vl, 0);
        cyc(1'b1, 1'b1);
        chk("ferr_clear", fel, 0);
        send_frame(8'h0F, 1'b1, 1, 1'b0);
        chk("after_ferr", dout_l, 8'h0F);
        chk("after_ferr_v", vl, 1);

        ready_mode = 0;
        send_bit(1'b0, 4);
        for (int i = 0; i < 4; i++) send_bit(rd[0], 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", dout_l, 0);
        chk("midrst_valid", vl, 0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        rst_n = 1'b1;
        ready_mode = 1;
        cyc(1'b1, 1'b1);
        send_frame(8'h99, 1'b1, 4, 1'b0);
        chk("x99_lsb", dout_l, 8'h99);
        chk("x99_msb", dout_m, 8'h99);
        cyc(1'b1, 1'b1);

`ifdef SHIFT_RX_PARITY_EN
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        chk("par_ok", dout_l, 8'hA5);
        cyc(1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1, 1'b1);
        chk("par_err", perl, 1);
        chk("par_no_valid", vl, 0);
        cyc(1'b1, 1'b1);
`endif

        ready_mode = 2;
        for (int f = 0; f < 300; f++) begin
            rd = W'($urandom);
            sp = $urandom_range(1, 3);
            for (int g = $urandom_range(0, 2); g > 0; g--) send_bit(1'b1, sp);
`ifdef SHIFT_RX_PARITY_EN
            send_frame(rd, 1'($urandom_range(0, 7) != 0), sp, 1'($urandom_range(0, 5) == 0));
`else
            send_frame(rd, 1'($urandom_range(0, 7) != 0), sp, 1'b0);
`endif
        end
        repeat (4) cyc(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
